// File: rtl/store_narrow_unit.sv
// Store path for sb/sh/sw into word-organised memory; narrow stores use read-modify-write.
// Optional narrowing-overflow flag on `ovf` is built when STORE_NARROW_OVF_EN is defined.
module store_narrow_unit #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   output logic              ready,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [1:0]        size,
   output logic              done,
   output logic              err,
   output logic              ovf,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_re,
   input  logic [31:0]       mem_rdata,
   output logic              mem_we,
   output logic [31:0]       mem_wdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      READ  = 2'b01,
      WRITE = 2'b10,
      FAULT = 2'b11
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t state, state_nxt;

   logic [ADDR_W-1:0] addr_p0;
   logic [31:0]       wdata_p0;
   logic [1:0]        size_p0;
   logic [31:0]       rdata_p1;
   logic              accept;
   logic              misaligned;
   logic [ADDR_W-1:0] word_addr;

   // Insert the narrowed lane (big-endian: offset 0 is the most significant lane).
   function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                              input logic [31:0] val,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off);
      logic [31:0] m;
      m = word;
      if (sz == SZ_BYTE) begin
         case (off)
            2'd0:    m[31:24] = val[7:0];
            2'd1:    m[23:16] = val[7:0];
            2'd2:    m[15:8]  = val[7:0];
            default: m[7:0]   = val[7:0];
         endcase
      end else if (sz == SZ_HALF) begin
         if (off[1]) m[15:0]  = val[15:0];
         else        m[31:16] = val[15:0];
      end else begin
         m = val;
      end
      return m;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      logic bad;
      case (sz)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

`ifdef STORE_NARROW_OVF_EN
   // Flag values that do not survive narrowing as a signed quantity.
   function automatic logic narrow_ovf(input logic [1:0] sz, input logic [31:0] val);
      logic o;
      case (sz)
         SZ_BYTE: o = (val[31:8]  != {24{val[7]}});
         SZ_HALF: o = (val[31:16] != {16{val[15]}});
         default: o = 1'b0;
      endcase
      return o;
   endfunction
`endif

   assign accept     = req && (state == IDLE);
   assign misaligned = is_misaligned(size, addr[1:0]);
   assign word_addr  = {addr_p0[ADDR_W-1:2], 2'b00};

   // Control state: the only reset-sensitive register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Request capture on accept and read-data capture at the READ->WRITE edge.
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0  <= addr;
         wdata_p0 <= wdata;
         size_p0  <= size;
      end
      if (state == READ) rdata_p1 <= mem_rdata;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (misaligned)           state_nxt = FAULT;
               else if (size == SZ_WORD) state_nxt = WRITE;
               else                      state_nxt = READ;
            end
         end
         READ:    state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         FAULT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         IDLE: ready = 1'b1;
         READ: begin
            mem_re   = 1'b1;
            mem_addr = word_addr;
         end
         WRITE: begin
            mem_we    = 1'b1;
            mem_addr  = word_addr;
            mem_wdata = merge_lane(rdata_p1, wdata_p0, size_p0, addr_p0[1:0]);
            done      = 1'b1;
         end
         FAULT: begin
            done = 1'b1;
            err  = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef STORE_NARROW_OVF_EN
   assign ovf = (state == WRITE) && narrow_ovf(size_p0, wdata_p0);
`else
   assign ovf = 1'b0;
`endif

endmodule
